// File: rtl/zeroriscy_fetch_pkg.sv
// zeroriscy_fetch_pkg: shared entry type and RV32C helpers for the prefetch queue
package zeroriscy_fetch_pkg;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [31:0]        addr;
    logic [INSTR_W-1:0] rdata;
    logic               err;
    logic               valid;
  } fetch_entry_t;
  function automatic logic is_compressed(input logic [1:0] op);
    return op != 2'b11;
  endfunction
endpackage

// File: rtl/zeroriscy_fetch_realign.sv
// zeroriscy_fetch_realign: picks head/second words (stored or bypass) and realigns the presented instruction
module zeroriscy_fetch_realign
  import zeroriscy_fetch_pkg::*;
(
  input  fetch_entry_t        e0_i,
  input  logic [INSTR_W-1:0]  e1_rdata_i,
  input  logic                e1_err_i,
  input  logic                e1_valid_i,
  input  fetch_entry_t        in_i,
  output logic [INSTR_W-1:0]  out_rdata_o,
  output logic [31:0]         out_addr_o,
  output logic                out_valid_o,
  output logic                out_err_o,
  output logic                out_valid_stored_o,
  output logic                compressed_o,
  output logic                head_err_o
);
  fetch_entry_t       w0;
  logic [INSTR_W-1:0] w1_rdata;
  logic               w1_err, w1_ok, unal, need2;
  always_comb begin
    w0                 = e0_i.valid ? e0_i : in_i;
    w1_rdata           = e1_valid_i ? e1_rdata_i : in_i.rdata;
    w1_err             = e1_valid_i ? e1_err_i : in_i.err;
    w1_ok              = e1_valid_i | (e0_i.valid & in_i.valid);
    unal               = w0.addr[1];
    compressed_o       = is_compressed(unal ? w0.rdata[17:16] : w0.rdata[1:0]);
    head_err_o         = w0.err;
    // an errored head is presented at once; only a clean unaligned 32-bit op needs W1
    need2              = unal & ~compressed_o & ~w0.err;
    out_addr_o         = w0.addr;
    out_rdata_o        = unal ? {w1_rdata[15:0], w0.rdata[31:16]} : w0.rdata;
    out_valid_o        = need2 ? w1_ok : w0.valid;
    out_err_o          = w0.err | (need2 & w1_err);
    out_valid_stored_o = need2 ? e1_valid_i : e0_i.valid;
  end
endmodule

// File: rtl/zeroriscy_prefetch_queue.sv
// zeroriscy_prefetch_queue: DEPTH-word instruction prefetch buffer with RV32C realignment
module zeroriscy_prefetch_queue
  import zeroriscy_fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic [31:0]        in_addr_i,
  input  logic [INSTR_W-1:0] in_rdata_i,
  input  logic               in_err_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_rdata_o,
  output logic [31:0]        out_addr_o,
  output logic               out_err_o,
  output logic               out_valid_stored_o,
  output logic [OCC_W-1:0]   occupancy_o
);
  fetch_entry_t [DEPTH-1:0] entries_q, entries_d, pushed;
  fetch_entry_t             in_e;
  logic                     comp, head_err, pop, shift;
  assign in_e = '{addr: in_addr_i, rdata: in_rdata_i, err: in_err_i, valid: in_valid_i};
  zeroriscy_fetch_realign u_realign (
    .e0_i               (entries_q[0]),
    .e1_rdata_i         (entries_q[1].rdata),
    .e1_err_i           (entries_q[1].err),
    .e1_valid_i         (entries_q[1].valid),
    .in_i               (in_e),
    .out_rdata_o        (out_rdata_o),
    .out_addr_o         (out_addr_o),
    .out_valid_o        (out_valid_o),
    .out_err_o          (out_err_o),
    .out_valid_stored_o (out_valid_stored_o),
    .compressed_o       (comp),
    .head_err_o         (head_err)
  );
  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < DEPTH; i++) occupancy_o = occupancy_o + OCC_W'(entries_q[i].valid);
  end
  assign in_ready_o = occupancy_o <= OCC_W'(DEPTH - 2);
  assign pop        = out_valid_o & out_ready_i;
  // only a clean aligned compressed op leaves the head word in place
  assign shift      = out_addr_o[1] | ~comp | head_err;
  always_comb begin
    pushed = entries_q;
    for (int i = 0; i < DEPTH; i++)
      if (in_valid_i && occupancy_o == OCC_W'(i)) pushed[i] = in_e;
    entries_d = pushed;
    if (pop && shift) begin
      for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = pushed[i+1];
      entries_d[DEPTH-1].valid = 1'b0;
      entries_d[0].addr = {out_addr_o[31:2] + 30'd1, out_addr_o[1] & ~comp & ~head_err, 1'b0};
    end else if (pop) begin
      entries_d[0].addr = {out_addr_o[31:2], 2'b10};
    end
    if (clear_i) begin
      entries_d = entries_q;
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) entries_q <= '0;
    else     entries_q <= entries_d;
  end
endmodule
